// File: rtl/sn_pkg.sv
// Shared stochastic-number types and helpers: decoder state, default window size, bipolar mapping.
package sn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam int WIN_LOG2_DEF = 4;

    // Unipolar ones-count to bipolar value: 2*ones - 2^win_log2.
    function automatic int to_bipolar(input int ones, input int win_log2);
        return (ones << 1) - (1 << win_log2);
    endfunction

endpackage

// File: rtl/sn_stream_decoder_if.sv
// Bitstream input, control strobes and result handshake of the stochastic decoder.
interface sn_stream_decoder_if #(
    parameter int WIN_LOG2 = 4
);
    logic                       start;
    logic                       stop;
    logic                       cont;
    logic                       sn_bit;
    logic                       sn_valid;
    logic                       result_ready;
    logic                       clear_ovr;
    logic                       result_valid;
    logic [WIN_LOG2:0]          result_ones;
    logic signed [WIN_LOG2+1:0] result_bip;
    logic                       busy;
    logic                       overrun;

    modport master (
        output start, stop, cont, sn_bit, sn_valid, result_ready, clear_ovr,
        input  result_valid, result_ones, result_bip, busy, overrun
    );

    modport slave (
        input  start, stop, cont, sn_bit, sn_valid, result_ready, clear_ovr,
        output result_valid, result_ones, result_bip, busy, overrun
    );
endinterface

// File: rtl/sn_window_counter.sv
// Counts valid bits and ones over a 2^WIN_LOG2 window; last flags the closing bit.
// Latency: final_cnt is combinational on the closing bit. No backpressure; en gates counting.
module sn_window_counter #(
    parameter int WIN_LOG2 = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              sn_bit,
    output logic              last,
    output logic [WIN_LOG2:0] final_cnt
);
    logic [WIN_LOG2-1:0] samp_cnt;
    logic [WIN_LOG2:0]   ones_acc;

    assign last      = en && (samp_cnt == {WIN_LOG2{1'b1}});
    // One bit wider than the window index so an all-ones window reads N, not 0.
    assign final_cnt = ones_acc + {{WIN_LOG2{1'b0}}, sn_bit};

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            samp_cnt <= '0;
            ones_acc <= '0;
        end else if (clr || last) begin
            samp_cnt <= '0;
            ones_acc <= '0;
        end else if (en) begin
            samp_cnt <= samp_cnt + WIN_LOG2'(1);
            ones_acc <= final_cnt;
        end
    end
endmodule

// File: rtl/sn_stream_decoder.sv
// Stochastic bitstream to binary: ones-count and bipolar value per 2^WIN_LOG2 valid bits.
// Latency: result registered one edge after the closing bit; cont mode runs windows back to back.
// Backpressure: result held until result_ready; a window finishing on a held result is dropped and flags overrun.
module sn_stream_decoder
    import sn_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    sn_stream_decoder_if.slave bus
);
    state_t                     state_q, state_d;
    logic                       cnt_clr, cnt_en, cnt_last;
    logic                       win_done, load;
    logic [WIN_LOG2:0]          final_cnt;
    logic signed [WIN_LOG2+1:0] bip_d;
    logic                       result_valid_q, overrun_q;
    logic [WIN_LOG2:0]          result_ones_q;
    logic signed [WIN_LOG2+1:0] result_bip_q;

    sn_window_counter #(.WIN_LOG2(WIN_LOG2)) u_win_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (cnt_clr),
        .en        (cnt_en),
        .sn_bit    (bus.sn_bit),
        .last      (cnt_last),
        .final_cnt (final_cnt)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start && !bus.stop) state_d = ACCUM;
            ACCUM:   if (bus.stop || (cnt_last && !bus.cont)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_en  = 1'b0;
        cnt_clr = 1'b1;
        if (state_q == ACCUM) begin
            cnt_en  = bus.sn_valid;
            cnt_clr = bus.stop;
        end
    end

    // A stop on the closing bit discards that window entirely.
    assign win_done = cnt_last && !bus.stop;
    assign load     = win_done && (!result_valid_q || bus.result_ready);
    assign bip_d    = $signed((WIN_LOG2+2)'(to_bipolar(int'(final_cnt), WIN_LOG2)));

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            result_valid_q <= 1'b0;
            result_ones_q  <= '0;
            result_bip_q   <= '0;
            overrun_q      <= 1'b0;
        end else begin
            if (load) begin
                result_valid_q <= 1'b1;
                result_ones_q  <= final_cnt;
                result_bip_q   <= bip_d;
            end else if (result_valid_q && bus.result_ready) begin
                result_valid_q <= 1'b0;
            end
            if (win_done && !load)  overrun_q <= 1'b1;
            else if (bus.clear_ovr) overrun_q <= 1'b0;
        end
    end

    assign bus.busy         = (state_q == ACCUM);
    assign bus.result_valid = result_valid_q;
    assign bus.result_ones  = result_ones_q;
    assign bus.result_bip   = result_bip_q;
    assign bus.overrun      = overrun_q;
endmodule

// File: doc/sn_stream_decoder.md
# sn_stream_decoder

Stochastic-to-binary decoder: receives a qualified serial stochastic bitstream (e.g. a MUX-adder output or an external SN pin) and counts ones over a fixed window of 2^WIN_LOG2 valid bits. It returns both the unipolar ones-count and the bipolar signed value through a registered valid/ready result port. It sits downstream of the LFSR/comparator stochastic encoders and replaces the ad-hoc 8-cycle up-counter, adding exact full-scale counting, backpressure and overrun reporting.

## Interface
- WIN_LOG2, 4, window length N = 2^WIN_LOG2 valid bits (4 matches the 4-bit encoder probabilities).
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-high. Despite the name, 1 = reset.
- start  in  1  in IDLE, begins a window; ignored elsewhere.
- stop  in  1  abort: ACCUM → IDLE, partial count discarded; wins over start in the same cycle.
- cont  in  1  continuous mode; sampled at window completion.
- sn_bit  in  1  stochastic bit; counted only when sn_valid=1.
- sn_valid  in  1  bit qualifier.
- result_ready  in  1  consumer accepts result.
- clear_ovr  in  1  clears overrun.
- result_valid  out  1  result registers hold an unaccepted result.
- result_ones  out  WIN_LOG2+1  ones count, 0..N.
- result_bip  out  WIN_LOG2+2 signed  2·ones − N, range −N..+N.
- busy  out  1  state is ACCUM.
- overrun  out  1  sticky; a completed window was dropped.

## Operation
- States: IDLE, ACCUM.
  - IDLE: on start and not stop, go to ACCUM. Clear ones_acc and samp_cnt.
  - ACCUM: on each sn_valid, samp_cnt += 1 and ones_acc += sn_bit.
- Window completion: in ACCUM, sn_valid=1 and samp_cnt = N−1.
  - Final count = ones_acc + sn_bit, computed at full WIN_LOG2+1 width. All-ones gives N with no wrap and no overflow.
  - Counters clear. If cont=1, stay in ACCUM; the next valid bit is bit 0 of the new window. Otherwise go to IDLE.
- Result load on completion:
  - If result_valid=0, or result_valid & result_ready in the same cycle: load result_ones and result_bip; result_valid = 1.
  - Otherwise: drop the new result, keep the old one, set overrun = 1.
- Handshake: result_valid & result_ready with no completion → result_valid = 0. Data registers hold their last value after acceptance.
- stop in ACCUM: go to IDLE next cycle. Counters clear and no result is produced, even if the stop cycle is also a completion cycle (stop wins).
- overrun: set as above; cleared by clear_ovr. If set and clear happen in the same cycle, set wins.
- Bipolar arithmetic: result_bip = (ones << 1) − N, in WIN_LOG2+2 bits, two's complement.
- Reset (asynchronous): state IDLE; counters 0; result_valid, result_ones, result_bip, overrun and busy all 0.

## Timing
- Latency: completion on cycle k → result_valid and data visible after edge k+1.
- busy rises the cycle after start is accepted. It falls the cycle after a non-cont completion or a stop.
- Back-to-back windows in cont mode: no dead cycles. The throughput limit is N valid bits per result.
- sn_valid gaps stall counting only; gaps have no timeout.
- Reset mid-window: outputs go to 0 asynchronously, without waiting for a clock edge. The partial window is lost.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package sn_pkg holds:
  - the state typedef (IDLE, ACCUM);
  - the default WIN_LOG2 constant;
  - the bipolar conversion function, shared with future stochastic blocks.
- One sub-module, sn_window_counter: samp_cnt/ones_acc with clear, enable and bit inputs. It outputs last and the final count. The FSM, result registers, handshake and overrun logic stay in sn_stream_decoder.

## Test plan
All scenarios use WIN_LOG2 = 4, N = 16.
- Reset: assert rst_n mid-ACCUM with 5 bits counted → all outputs 0 immediately. After release, state is IDLE and busy = 0.
- Full scale: start, then 16 valid ones → result_ones = 16, result_bip = +16, result_valid one cycle after the 16th bit. Repeat with 16 zeros → result_ones = 0, result_bip = −16.
- Gapped stream: sn_valid every other cycle, pattern 1010… (8 ones in 16 valid bits), with sn_bit=1 on invalid cycles → result_ones = 8, result_bip = 0, completion after 32 cycles.
- Backpressure: cont = 1, result_ready = 0, window 1 has 3 ones and window 2 has 12 ones → result stays at 3 and overrun = 1. Then ready = 1 accepts 3; clear_ovr clears overrun. Ready asserted exactly on a completion cycle → new value loads, overrun stays 0.
- Abort: stop after 5 ones → IDLE next cycle, no result_valid. Then start and a window with 3 ones → result_ones = 3. Stop and start together in IDLE → stays IDLE.
- Random: LFSR-driven sn_bit for 1000 windows, scoreboard compares result_ones/result_bip against a software popcount.
